// File: rtl/caxi4interconnect_cdc_pkg.sv
// Shared definitions for the gen2 CDC FIFO write/read-side controllers.
//   - Gray/binary conversion helpers on a PtrMaxW-bit vector. Callers zero-extend
//     narrower pointers in and truncate the result back to their own width.
//   - Controller state encoding.
//   - Legal range of the pointer synchroniser depth.
package caxi4interconnect_cdc_pkg;

  localparam int unsigned PtrMaxW       = 32;
  localparam int unsigned SyncStagesMin = 2;
  localparam int unsigned SyncStagesMax = 4;

  typedef enum logic [1:0] {
    StInit  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } cdc_state_e;

  // Zero-extended inputs convert correctly, so one width serves every pointer size.
  function automatic logic [PtrMaxW-1:0] bin2gray(input logic [PtrMaxW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PtrMaxW-1:0] gray2bin(input logic [PtrMaxW-1:0] gray);
    logic [PtrMaxW-1:0] bin;
    bin[PtrMaxW-1] = gray[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/caxi4interconnect_cdc_sync_bus.sv
// Multi-flop bus synchroniser for Gray-coded CDC pointers.
// Ports:
//   clk  - destination-domain clock
//   rst  - asynchronous active-low reset, clears every stage to 0
//   clr  - synchronous clear of every stage (flush)
//   din  - bus from the source domain (must be Gray coded)
//   dout - synchronised bus, SYNC_STAGES clocks behind din
module caxi4interconnect_cdc_sync_bus #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/caxi4interconnect_cdc_wr_ctrl_gen2.sv
// Write-side controller of the gen2 asynchronous CDC FIFO.
// Owns the binary/Gray write pointer, synchronises the read pointer and produces a
// registered ready (not-full) flag. Optional occupancy outputs under macro
// CAXI4_CDC_WR_LEVEL_EN (adds parameter AFULL_THRESH and ports almostFull/wrLevel).
// Ports:
//   clk, rst      - write clock, asynchronous active-low reset
//   terminate     - synchronous flush of the write side
//   rdPtr_gray    - Gray read pointer from the read domain (asynchronous)
//   infoInValid   - upstream has an entry
//   readyForInfo  - registered, FIFO can accept an entry
//   fifoWe        - RAM write enable (infoInValid & readyForInfo)
//   wrAddr        - RAM write address
//   wrPtr_gray    - registered Gray write pointer to the read domain
//   almostFull    - registered occupancy >= AFULL_THRESH (level feature only)
//   wrLevel       - registered occupancy estimate (level feature only)
module caxi4interconnect_cdc_wr_ctrl_gen2
  import caxi4interconnect_cdc_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 3,
  parameter int unsigned SYNC_STAGES = 2
`ifdef CAXI4_CDC_WR_LEVEL_EN
  ,
  parameter int unsigned AFULL_THRESH = 6
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  terminate,
  input  logic [ADDR_WIDTH:0]   rdPtr_gray,
  input  logic                  infoInValid,
  output logic                  readyForInfo,
  output logic                  fifoWe,
  output logic [ADDR_WIDTH-1:0] wrAddr,
`ifdef CAXI4_CDC_WR_LEVEL_EN
  output logic                  almostFull,
  output logic [ADDR_WIDTH:0]   wrLevel,
`endif
  output logic [ADDR_WIDTH:0]   wrPtr_gray
);

  localparam int unsigned PtrW = ADDR_WIDTH + 1;
  // Out-of-range synchroniser depths are clamped into the legal range.
  localparam int unsigned Stages = (SYNC_STAGES < SyncStagesMin) ? SyncStagesMin :
                                   (SYNC_STAGES > SyncStagesMax) ? SyncStagesMax :
                                   SYNC_STAGES;
  // Full: Gray pointers equal except the two MSBs, which are inverted.
  localparam logic [PtrW-1:0] FullMask = PtrW'(3) << (ADDR_WIDTH - 1);

  cdc_state_e      state_q, state_d;
  logic [2:0]      flushCnt_q, flushCnt_d;
  logic [PtrW-1:0] wrPtr_bin_q, wrPtr_bin_d;
  logic [PtrW-1:0] wrPtr_gray_q, wrPtr_gray_d;
  logic            ready_q, ready_d;

  logic [PtrW-1:0] rdSync_gray;
  logic [PtrW-1:0] wrPtr_bin_next;
  logic [PtrW-1:0] wrPtr_gray_next;
  logic            full_next;

  caxi4interconnect_cdc_sync_bus #(
    .WIDTH       (PtrW),
    .SYNC_STAGES (Stages)
  ) u_rdPtrSync (
    .clk  (clk),
    .rst  (rst),
    .clr  (terminate),
    .din  (rdPtr_gray),
    .dout (rdSync_gray)
  );

  assign fifoWe          = infoInValid & ready_q;
  assign wrPtr_bin_next  = wrPtr_bin_q + PtrW'(fifoWe);
  assign wrPtr_gray_next = PtrW'(bin2gray(PtrMaxW'(wrPtr_bin_next)));
  // rdSync lags the true read pointer, so this can only err towards full.
  assign full_next       = (wrPtr_gray_next == (rdSync_gray ^ FullMask));

  always_comb begin
    state_d      = state_q;
    flushCnt_d   = flushCnt_q;
    ready_d      = 1'b0;
    wrPtr_bin_d  = wrPtr_bin_next;
    wrPtr_gray_d = wrPtr_gray_next;
    if (terminate) begin
      // Any write accepted this cycle is discarded by the pointer clear.
      state_d      = StFlush;
      flushCnt_d   = '0;
      wrPtr_bin_d  = '0;
      wrPtr_gray_d = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          state_d = StRun;
          ready_d = ~full_next;
        end
        StRun: begin
          ready_d = ~full_next;
        end
        StFlush: begin
          // Ready stays low for Stages+1 cycles, counting the terminate edge.
          if (flushCnt_q == 3'(Stages)) begin
            state_d = StRun;
            ready_d = ~full_next;
          end else begin
            flushCnt_d = flushCnt_q + 3'd1;
          end
        end
        default: begin
          state_d = StInit;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StInit;
      flushCnt_q   <= '0;
      wrPtr_bin_q  <= '0;
      wrPtr_gray_q <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      flushCnt_q   <= flushCnt_d;
      wrPtr_bin_q  <= wrPtr_bin_d;
      wrPtr_gray_q <= wrPtr_gray_d;
      ready_q      <= ready_d;
    end
  end

  assign readyForInfo = ready_q;
  assign wrAddr       = wrPtr_bin_q[ADDR_WIDTH-1:0];
  assign wrPtr_gray   = wrPtr_gray_q;

`ifdef CAXI4_CDC_WR_LEVEL_EN
  logic [PtrW-1:0] rdSync_bin;
  logic [PtrW-1:0] level_d, level_q;
  logic            afull_d, afull_q;

  assign rdSync_bin = PtrW'(gray2bin(PtrMaxW'(rdSync_gray)));

  always_comb begin
    level_d = '0;
    // Level is only meaningful while running; zero in INIT and FLUSH.
    if (state_d == StRun) level_d = wrPtr_bin_next - rdSync_bin;
    afull_d = (level_d >= PtrW'(AFULL_THRESH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign wrLevel    = level_q;
  assign almostFull = afull_q;
`endif

endmodule

// File: tb/tb_caxi4interconnect_cdc_wr_ctrl_gen2.sv
module tb_caxi4interconnect_cdc_wr_ctrl_gen2;

  localparam int AW    = 3;
  localparam int SYNC  = 2;
  localparam int THR   = 6;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          rst;
  logic          terminate;
  logic [AW:0]   rdPtr_gray;
  logic          infoInValid;
  logic          readyForInfo;
  logic          fifoWe;
  logic [AW-1:0] wrAddr;
  logic [AW:0]   wrPtr_gray;
`ifdef CAXI4_CDC_WR_LEVEL_EN
  logic          almostFull;
  logic [AW:0]   wrLevel;
`endif

  caxi4interconnect_cdc_wr_ctrl_gen2 #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SYNC)
`ifdef CAXI4_CDC_WR_LEVEL_EN
    ,
    .AFULL_THRESH (THR)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .terminate    (terminate),
    .rdPtr_gray   (rdPtr_gray),
    .infoInValid  (infoInValid),
    .readyForInfo (readyForInfo),
    .fifoWe       (fifoWe),
    .wrAddr       (wrAddr),
`ifdef CAXI4_CDC_WR_LEVEL_EN
    .almostFull   (almostFull),
    .wrLevel      (wrLevel),
`endif
    .wrPtr_gray   (wrPtr_gray)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] b2g(input int b);
    logic [AW:0] v;
    v = (AW+1)'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int g2b(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  typedef struct {
    logic        inValid;
    logic        expWe;
    logic [AW:0] expGray;
    logic [2:0]  expAddr;
    logic        expReady;
  } vec_t;

  vec_t vecs[9];

  // Reference-model state (occupancy arithmetic on integers)
  int          mState;     // 0 init, 1 run, 2 flush
  int          flushLeft;
  int          mWr;
  int          totalWr;
  int          rdCnt;
  logic        mReady;
  int          mLevel;
  logic [AW:0] rdQ[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic expWe;
    int   occ;
    int   n;

    // 8 writes from empty, then a 9th attempt against a full FIFO
    vecs[0] = '{1'b1, 1'b1, 4'd1,  3'd1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 4'd3,  3'd2, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 4'd2,  3'd3, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 4'd6,  3'd4, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 4'd7,  3'd5, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'd5,  3'd6, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 4'd4,  3'd7, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 4'd12, 3'd0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 4'd12, 3'd0, 1'b0};

    rst = 1'b0; terminate = 1'b0; infoInValid = 1'b0; rdPtr_gray = '0;
    repeat (2) tick();
    chk("rst_ready", readyForInfo, 0);
    chk("rst_we", fifoWe, 0);
    chk("rst_addr", wrAddr, 0);
    chk("rst_gray", wrPtr_gray, 0);
`ifdef CAXI4_CDC_WR_LEVEL_EN
    chk("rst_level", wrLevel, 0);
    chk("rst_afull", almostFull, 0);
`endif
    rst = 1'b1;
    #1;
    chk("init_ready_pre_edge", readyForInfo, 0);
    tick();
    chk("init_ready", readyForInfo, 1);
    chk("init_gray", wrPtr_gray, 0);

    for (int i = 0; i < 9; i++) begin
      infoInValid = vecs[i].inValid;
      #1;
      chk($sformatf("tbl%0d_we", i), fifoWe, vecs[i].expWe);
      tick();
      chk($sformatf("tbl%0d_gray", i), wrPtr_gray, vecs[i].expGray);
      chk($sformatf("tbl%0d_addr", i), wrAddr, vecs[i].expAddr);
      chk($sformatf("tbl%0d_ready", i), readyForInfo, vecs[i].expReady);
    end

    // Read side frees one slot: ready returns within SYNC+1 clocks
    infoInValid = 1'b0;
    rdPtr_gray = b2g(1);
    n = 0;
    while (!readyForInfo && n < SYNC + 1) begin
      tick();
      n++;
    end
    chk("recov_ready", readyForInfo, 1);
    infoInValid = 1'b1;
    #1;
    chk("recov_we", fifoWe, 1);
    tick();
    chk("recov_gray", wrPtr_gray, b2g(9));
    chk("recov_ready_fall", readyForInfo, 0);
    #1;
    chk("recov_no_we", fifoWe, 0);
    tick();
    chk("recov_gray_hold", wrPtr_gray, b2g(9));

    // Flush to a clean state, fill to 5, then terminate with a write pending
    infoInValid = 1'b0; terminate = 1'b1; rdPtr_gray = '0;
    tick();
    terminate = 1'b0;
    repeat (SYNC + 1) tick();
    chk("clean_ready", readyForInfo, 1);
    infoInValid = 1'b1;
    repeat (5) tick();
    chk("occ5_gray", wrPtr_gray, b2g(5));
    terminate = 1'b1;
    #1;
    chk("term_we_seen", fifoWe, 1);
    tick();
    terminate = 1'b0; infoInValid = 1'b0;
    chk("term_gray", wrPtr_gray, 0);
    chk("term_addr", wrAddr, 0);
    chk("term_ready", readyForInfo, 0);
    for (int k = 0; k < SYNC; k++) begin
      tick();
      chk($sformatf("flush%0d_ready", k), readyForInfo, 0);
    end
    tick();
    chk("flush_end_ready", readyForInfo, 1);
    chk("flush_end_gray", wrPtr_gray, 0);

    // Pointer wrap with the reader tracking every write
    for (int i = 1; i <= 2 * DEPTH; i++) begin
      infoInValid = 1'b1;
      tick();
      chk($sformatf("wrap%0d_ready", i), readyForInfo, 1);
      rdPtr_gray = b2g(i % PMOD);
    end
    chk("wrap_gray", wrPtr_gray, 0);
    infoInValid = 1'b0;
    repeat (SYNC) tick();

    // Level outputs and asynchronous reset mid-burst
    infoInValid = 1'b1;
    repeat (THR - 1) tick();
`ifdef CAXI4_CDC_WR_LEVEL_EN
    chk("lvl5_level", wrLevel, THR - 1);
    chk("lvl5_afull", almostFull, 0);
`endif
    tick();
    chk("lvl6_gray", wrPtr_gray, b2g(THR));
`ifdef CAXI4_CDC_WR_LEVEL_EN
    chk("lvl6_level", wrLevel, THR);
    chk("lvl6_afull", almostFull, 1);
`endif
    rst = 1'b0;
    #1;
    chk("arst_ready", readyForInfo, 0);
    chk("arst_we", fifoWe, 0);
    chk("arst_addr", wrAddr, 0);
    chk("arst_gray", wrPtr_gray, 0);
`ifdef CAXI4_CDC_WR_LEVEL_EN
    chk("arst_level", wrLevel, 0);
    chk("arst_afull", almostFull, 0);
`endif

    // Randomised run against the occupancy model
    infoInValid = 1'b0; rdPtr_gray = '0;
    tick();
    mState = 0; flushLeft = 0; mWr = 0; totalWr = 0; rdCnt = 0; mReady = 1'b0; mLevel = 0;
    rdQ.delete();
    for (int i = 0; i < SYNC; i++) rdQ.push_back('0);
    rst = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      infoInValid = ($urandom_range(0, 99) < 70);
      terminate   = ($urandom_range(0, 99) < 3);
      if (rdCnt < totalWr && $urandom_range(0, 1) == 1) rdCnt++;
      rdPtr_gray = b2g(rdCnt % PMOD);
      #1;
      expWe = infoInValid & mReady;
      chk("rnd_we", fifoWe, expWe);
      if (terminate) begin
        mWr = 0; totalWr = 0; rdCnt = 0;
        for (int i = 0; i < SYNC; i++) rdQ[i] = '0;
        mState = 2; flushLeft = SYNC + 1; mReady = 1'b0; mLevel = 0;
      end else begin
        if (expWe) begin
          mWr = (mWr + 1) % PMOD;
          totalWr++;
        end
        occ = (mWr - g2b(rdQ[SYNC-1]) + PMOD) % PMOD;
        if (mState == 0) mState = 1;
        else if (mState == 2) begin
          flushLeft--;
          if (flushLeft == 0) mState = 1;
        end
        if (mState == 1) begin
          mReady = (occ != DEPTH);
          mLevel = occ;
        end else begin
          mReady = 1'b0;
          mLevel = 0;
        end
        rdQ.push_front(rdPtr_gray);
        void'(rdQ.pop_back());
      end
      tick();
      terminate = 1'b0;
      chk("rnd_ready", readyForInfo, mReady);
      chk("rnd_gray", wrPtr_gray, b2g(mWr));
      chk("rnd_addr", wrAddr, mWr % DEPTH);
`ifdef CAXI4_CDC_WR_LEVEL_EN
      chk("rnd_level", wrLevel, mLevel);
      chk("rnd_afull", almostFull, (mLevel >= THR));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/caxi4interconnect_cdc_wr_ctrl_gen2.md
# caxi4interconnect_cdc_wr_ctrl_gen2

Parametrised write-side controller for the interconnect's asynchronous clock-domain-crossing FIFOs. It owns the write pointer (binary and Gray), synchronises the read pointer from the read domain and derives a registered full flag. It drives a qualified valid/ready write handshake into the FIFO RAM. It sits in the write clock domain, between the upstream AXI channel source and the dual-port CDC buffer, and pairs with the read-side controller of the same generation.

## Interface
Parameters:
- ADDR_WIDTH, 3, log2 of FIFO depth; pointers are ADDR_WIDTH+1 bits, including the wrap bit.
- SYNC_STAGES, 2, flop stages on the read-pointer synchroniser; legal range 2–4.
- AFULL_THRESH, 6, occupancy at or above which almostFull asserts; legal range 1 to 2^ADDR_WIDTH−1.

Ports:
- clk, in, 1, write-domain clock.
- rst, in, 1, asynchronous, active-low reset.
- terminate, in, 1, synchronous flush of the write side; asserted by the system to both sides in the same transaction window.
- rdPtr_gray, in, ADDR_WIDTH+1, read pointer in Gray code, from the read domain (asynchronous).
- infoInValid, in, 1, upstream has an entry to write.
- readyForInfo, out, 1, FIFO can accept an entry; registered.
- fifoWe, out, 1, RAM write enable, equal to infoInValid & readyForInfo.
- wrAddr, out, ADDR_WIDTH, RAM write address; the low bits of the binary write pointer.
- wrPtr_gray, out, ADDR_WIDTH+1, registered Gray write pointer sent to the read domain.
- almostFull, out, 1, occupancy ≥ AFULL_THRESH; present only with the level feature.
- wrLevel, out, ADDR_WIDTH+1, registered occupancy estimate; present only with the level feature.

## Operation
- State machine:
  - INIT is entered on reset; readyForInfo = 0. It moves to RUN on the first clk edge after rst deasserts.
  - RUN is normal operation.
  - FLUSH is entered from any state when terminate = 1. It holds readyForInfo = 0 for SYNC_STAGES+1 cycles, then returns to RUN. terminate asserted during FLUSH restarts the count.
- Write pointer:
  - wrPtr_bin increments by 1 on each clk edge with fifoWe = 1 and wraps modulo 2^(ADDR_WIDTH+1).
  - wrPtr_gray = bin2gray(wrPtr_bin), registered together with wrPtr_bin, so only one bit changes per write.
- Synchroniser: rdPtr_gray passes through SYNC_STAGES flops, each reset to 0, giving rdSync_gray.
- Full detection:
  - full_next is true when gray(wrPtr_bin_next) equals rdSync_gray with its two MSBs inverted and the remaining bits equal.
  - readyForInfo <= ~full_next in RUN.
  - A full flag that is stale-high is permitted, because it is conservative. A stale-low full flag must never occur.
- Handshake:
  - An entry is written on every cycle where infoInValid & readyForInfo.
  - infoInValid may drop without a transfer.
  - fifoWe never asserts while readyForInfo = 0.
- Terminate: wrPtr_bin, wrPtr_gray and the synchroniser flops clear to 0 on the same edge. A fifoWe in that cycle is discarded.
- Reset mid-operation: all registers clear immediately and asynchronously. Outputs return to their reset values with no clk edge required.

## Timing
- Reset values: readyForInfo = 0, fifoWe = infoInValid & 0 = 0, wrAddr = 0, wrPtr_gray = 0, almostFull = 0, wrLevel = 0.
- readyForInfo = 1 one clk edge after rst rises (INIT to RUN).
- Write to wrPtr_gray update: 1 cycle.
- A write that fills the last slot drops readyForInfo on the same edge, so there is zero overshoot.
- A read-side pointer advance can raise readyForInfo after at most SYNC_STAGES+1 write clocks.
- Throughput: 1 write per clk while not full.

## Configuration
- Macro CAXI4_CDC_WR_LEVEL_EN.
- When defined:
  - rdSync_gray is converted with gray2bin.
  - wrLevel is registered as (wrPtr_bin − rdSync_bin) mod 2^(ADDR_WIDTH+1).
  - almostFull is registered as wrLevel ≥ AFULL_THRESH, computed from the post-write pointer.
  - wrLevel is 0 in INIT and FLUSH.
- When undefined: the almostFull and wrLevel ports and their logic are absent. The core handshake is unchanged.

## Structure
- Shared package caxi4interconnect_cdc_pkg holds:
  - the bin2gray and gray2bin functions, parametrised by width;
  - the state encoding (INIT, RUN, FLUSH);
  - the constant for the SYNC_STAGES legal range, reused by the read-side controller.
- One sub-module, caxi4interconnect_cdc_sync_bus: a SYNC_STAGES-deep, width-parametrised synchroniser with asynchronous active-low reset to 0. The same sub-module is instantiated by the read-side controller.

## Test plan
All scenarios use ADDR_WIDTH=3, SYNC_STAGES=2 and AFULL_THRESH=6.
- Reset release with rdPtr_gray=0: readyForInfo goes 0→1 on the first edge, and wrPtr_gray=0.
- 8 back-to-back writes with rdPtr_gray held at 0:
  - wrPtr_gray steps 0,1,3,2,6,7,5,4, then 12 (binary 8);
  - readyForInfo falls on the 8th write edge;
  - the 9th infoInValid produces no fifoWe.
- With the FIFO full, drive rdPtr_gray to 1 (binary 1): readyForInfo returns within 3 clks, and exactly one further write is accepted before it falls again.
- Pointer wrap: perform 16 writes, with the read pointer tracking each write after the sync delay. wrPtr_gray returns to 0 and no false full occurs.
- Terminate at occupancy 5: on the same edge wrPtr_gray=0 and the write is dropped; readyForInfo=0 for 3 clks, then 1.
- With CAXI4_CDC_WR_LEVEL_EN defined and rdPtr_gray=0: after 6 writes wrLevel=6 and almostFull=1; after 5 writes almostFull=0. Assert rst low mid-burst: all outputs go to 0 without a clk edge.
